// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared limits and round-robin helper for the SRAM arbiter
//
// Purpose : Common limits and the round-robin search used by sram_rr_pick.
// Contents: NREQ_MAX, RD_LAT_MAX, PTR_W localparams; rr_pick() function.
package sram_arb_pkg;

    localparam int NREQ_MAX   = 8;
    localparam int RD_LAT_MAX = 3;
    localparam int PTR_W      = $clog2(NREQ_MAX);

    // One-hot pick of the first set candidate among ports 1..nreq-1.
    // The search starts at ptr and wraps from nreq-1 back to 1.
    // Port 0 is never considered.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] cand,
        input logic [PTR_W-1:0]    ptr,
        input int                  nreq
    );
        logic [NREQ_MAX-1:0] pick;
        logic                found;
        int                  idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 0; off < NREQ_MAX - 1; off++) begin
            if (off < nreq - 1) begin
                idx = int'(ptr) + off;
                if (idx > nreq - 1) begin
                    idx = idx - (nreq - 1);
                end
                if (!found && cand[idx[PTR_W-1:0]]) begin
                    pick[idx[PTR_W-1:0]] = 1'b1;
                    found                = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - combinational round-robin search over ports 1..NREQ-1
//
// Purpose: Wraps rr_pick() for an NREQ-wide candidate vector.
// Ports  : cand in  [NREQ-1:0]   candidate per port (bit 0 ignored)
//          ptr  in  [PTR_W-1:0]  search start port (1..NREQ-1)
//          gnt  out [NREQ-1:0]   one-hot winner, all 0 when no candidate
module sram_rr_pick
    import sram_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  cand,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt
);

    logic [NREQ_MAX-1:0] cand_ext;
    logic [NREQ_MAX-1:0] pick;

    assign cand_ext = NREQ_MAX'(cand);
    assign pick     = rr_pick(cand_ext, ptr, NREQ);
    assign gnt      = pick[NREQ-1:0];

    // Bits above NREQ-1 are always zero for a legal NREQ.
    generate
        if (NREQ < NREQ_MAX) begin : g_hi
            logic unused_hi;
            assign unused_hi = |pick[NREQ_MAX-1:NREQ];
        end
    endgenerate

endmodule

// File: rtl/sram_arb_nport.sv
// rtl/sram_arb_nport.sv - N-port single-port SRAM arbiter with fixed-priority port 0
//
// Purpose: Port 0 always wins and is never stalled. Ports 1..NREQ-1 share the
//          leftover cycles round-robin, each with a one-entry pending buffer.
//          Read data is tagged with a one-hot valid RD_LAT cycles after grant.
// Ports  : clk, rst_n                 clock, async active-low reset
//          req_en/we/addr/wbe/wdata   packed per-port requests
//          req_rdy                    per-port accept
//          rdata, rdata_vld           shared read data, one-hot owner
//          sram_en/we/addr/wbe/wdata  SRAM macro command
//          sram_rdata                 SRAM read data
module sram_arb_nport
    import sram_arb_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 9,
    parameter int BW     = DW / 8,
    parameter int NREQ   = 4,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_en,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*BW-1:0]   req_wbe,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      req_rdy,
    output logic [DW-1:0]        rdata,
    output logic [NREQ-1:0]      rdata_vld,
    output logic                 sram_en,
    output logic                 sram_we,
    output logic [AW-1:0]        sram_addr,
    output logic [BW-1:0]        sram_wbe,
    output logic [DW-1:0]        sram_wdata,
    input  logic [DW-1:0]        sram_rdata
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] wbe;
        logic [DW-1:0] wdata;
    } sram_req_t;

    logic [NREQ-1:0]  pend_vld;
    sram_req_t        pend_q   [NREQ];
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_nxt;
    logic [NREQ-1:0]  tag_q    [RD_LAT];

    logic [NREQ-1:0]  live;
    logic [NREQ-1:0]  cand;
    logic [NREQ-1:0]  gnt_rr;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  tag_in;
    sram_req_t        cand_req [NREQ];
    sram_req_t        sel;

    // Candidate view: a pending entry shadows the live inputs, which the
    // requester may keep driving while it is not ready.
    always_comb begin
        req_rdy    = ~pend_vld;
        req_rdy[0] = 1'b1;
        live       = req_en & req_rdy;
        cand       = pend_vld | live;
        cand[0]    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_vld[i]) begin
                cand_req[i] = pend_q[i];
            end else begin
                cand_req[i].addr  = req_addr[i*AW +: AW];
                cand_req[i].we    = req_we[i];
                cand_req[i].wbe   = req_wbe[i*BW +: BW];
                cand_req[i].wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    sram_rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .cand (cand),
        .ptr  (rr_ptr),
        .gnt  (gnt_rr)
    );

    // Port 0 preempts the round-robin winner outright.
    always_comb begin
        grant = req_en[0] ? NREQ'(1) : gnt_rr;
        sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel = sram_req_t'(sel | cand_req[i]);
            end
        end
        rr_nxt = rr_ptr;
        for (int i = 1; i < NREQ; i++) begin
            if (grant[i]) begin
                rr_nxt = (i == NREQ - 1) ? PTR_W'(1) : PTR_W'(i + 1);
            end
        end
        tag_in = (|grant && !sel.we) ? grant : '0;
    end

    assign sram_en    = |grant;
    assign sram_we    = sel.we;
    assign sram_addr  = sel.addr;
    assign sram_wbe   = sel.wbe;
    assign sram_wdata = sel.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= '0;
            rr_ptr   <= PTR_W'(1);
            for (int i = 0; i < NREQ; i++) begin
                pend_q[i] <= '0;
            end
            for (int j = 0; j < RD_LAT; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            // Capture and release are exclusive per port: capture needs
            // rdy=1, release needs pend_vld=1.
            for (int i = 1; i < NREQ; i++) begin
                if (live[i] && !grant[i]) begin
                    pend_vld[i] <= 1'b1;
                    pend_q[i]   <= cand_req[i];
                end else if (pend_vld[i] && grant[i]) begin
                    pend_vld[i] <= 1'b0;
                end
            end
            rr_ptr   <= rr_nxt;
            tag_q[0] <= tag_in;
            for (int j = 1; j < RD_LAT; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
        end
    end

    assign rdata_vld = tag_q[RD_LAT-1];
    assign rdata     = sram_rdata;

endmodule

// File: tb/tb_sram_arb_nport.sv
// tb/tb_sram_arb_nport.sv - directed bench for sram_arb_nport (RD_LAT 1 and 3)
module tb_sram_arb_nport;

    localparam int DW   = 32;
    localparam int AW   = 9;
    localparam int BW   = 4;
    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req_en;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*BW-1:0] req_wbe;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      srd;

    logic [NREQ-1:0] rdy1, vld1, rdy3, vld3;
    logic [DW-1:0]   rdata1, rdata3, swdata1, swdata3;
    logic            sen1, swe1, sen3, swe3;
    logic [AW-1:0]   saddr1, saddr3;
    logic [BW-1:0]   swbe1, swbe3;

    always #5 clk = ~clk;

    sram_arb_nport #(.DW(DW), .AW(AW), .BW(BW), .NREQ(NREQ), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_wbe(req_wbe), .req_wdata(req_wdata),
        .req_rdy(rdy1), .rdata(rdata1), .rdata_vld(vld1),
        .sram_en(sen1), .sram_we(swe1), .sram_addr(saddr1), .sram_wbe(swbe1),
        .sram_wdata(swdata1), .sram_rdata(srd)
    );

    sram_arb_nport #(.DW(DW), .AW(AW), .BW(BW), .NREQ(NREQ), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_en(req_en), .req_we(req_we),
        .req_addr(req_addr), .req_wbe(req_wbe), .req_wdata(req_wdata),
        .req_rdy(rdy3), .rdata(rdata3), .rdata_vld(vld3),
        .sram_en(sen3), .sram_we(swe3), .sram_addr(saddr3), .sram_wbe(swbe3),
        .sram_wdata(swdata3), .sram_rdata(srd)
    );

    typedef struct {
        logic [3:0] en;
        logic [3:0] we;
        logic [8:0] a0, a1, a2, a3;
        logic [3:0] wbe;
        logic [3:0] xrdy;
        logic       xen;
        logic       xwe;
        logic [8:0] xaddr;
        logic [3:0] xwbe;
        logic [3:0] xvld;
    } row_t;

    row_t rows [12];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [31:0] wd(input logic [8:0] a);
        return 32'hD000_0000 | {23'b0, a};
    endfunction

    function automatic row_t mk(input logic [3:0] en, input logic [3:0] we,
                                input logic [8:0] a0, input logic [8:0] a1,
                                input logic [8:0] a2, input logic [8:0] a3,
                                input logic [3:0] wbe, input logic [3:0] xrdy,
                                input logic xen, input logic xwe,
                                input logic [8:0] xaddr, input logic [3:0] xwbe,
                                input logic [3:0] xvld);
        row_t r;
        r.en = en; r.we = we; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.a3 = a3;
        r.wbe = wbe; r.xrdy = xrdy; r.xen = xen; r.xwe = xwe;
        r.xaddr = xaddr; r.xwbe = xwbe; r.xvld = xvld;
        return r;
    endfunction

    task automatic drive(input logic [3:0] en, input logic [3:0] we,
                         input logic [8:0] a0, input logic [8:0] a1,
                         input logic [8:0] a2, input logic [8:0] a3,
                         input logic [3:0] wbe);
        req_en    = en;
        req_we    = we;
        req_addr  = {a3, a2, a1, a0};
        req_wbe   = {4{wbe}};
        req_wdata = {wd(a3), wd(a2), wd(a1), wd(a0)};
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        //            en       we       a0      a1      a2      a3      wbe     xrdy   en  we  xaddr   xwbe    xvld
        rows[0]  = mk(4'b0001, 4'b0000, 9'h010, 9'h000, 9'h000, 9'h000, 4'hF, 4'hF,    1, 0, 9'h010, 4'hF,   4'b0000);
        rows[1]  = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'hF,    0, 0, 9'h000, 4'h0,   4'b0001);
        rows[2]  = mk(4'b1111, 4'b0000, 9'h001, 9'h011, 9'h012, 9'h013, 4'hF, 4'hF,    1, 0, 9'h001, 4'hF,   4'b0000);
        rows[3]  = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'b0001, 1, 0, 9'h011, 4'hF,   4'b0001);
        rows[4]  = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'b0011, 1, 0, 9'h012, 4'hF,   4'b0010);
        rows[5]  = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'b0111, 1, 0, 9'h013, 4'hF,   4'b0100);
        rows[6]  = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'hF,    0, 0, 9'h000, 4'h0,   4'b1000);
        rows[7]  = mk(4'b0100, 4'b0100, 9'h000, 9'h000, 9'h0A5, 9'h000, 4'h3, 4'hF,    1, 1, 9'h0A5, 4'h3,   4'b0000);
        rows[8]  = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'hF,    0, 0, 9'h000, 4'h0,   4'b0000);
        rows[9]  = mk(4'b1010, 4'b0000, 9'h000, 9'h021, 9'h000, 9'h023, 4'hF, 4'hF,    1, 0, 9'h023, 4'hF,   4'b0000);
        rows[10] = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'b1101, 1, 0, 9'h021, 4'hF,   4'b1000);
        rows[11] = mk(4'b0000, 4'b0000, 9'h000, 9'h000, 9'h000, 9'h000, 4'hF, 4'hF,    0, 0, 9'h000, 4'h0,   4'b0010);

        srd = 32'hCAFE_F00D;
        drive(4'b0, 4'b0, 9'h0, 9'h0, 9'h0, 9'h0, 4'h0);
        repeat (2) @(posedge clk);
        #3;
        chk("rst_rdy", rdy1, 4'hF);
        chk("rst_en", sen1, 1'b0);
        chk("rst_we", swe1, 1'b0);
        chk("rst_addr", saddr1, 9'h0);
        chk("rst_wbe", swbe1, 4'h0);
        chk("rst_wdata", swdata1, 32'h0);
        chk("rst_vld1", vld1, 4'b0);
        chk("rst_vld3", vld3, 4'b0);
        chk("rdata_pass", rdata1, 32'hCAFE_F00D);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 12; r++) begin
            drive(rows[r].en, rows[r].we, rows[r].a0, rows[r].a1, rows[r].a2,
                  rows[r].a3, rows[r].wbe);
            #1;
            chk($sformatf("row%0d_rdy", r), rdy1, rows[r].xrdy);
            chk($sformatf("row%0d_en", r), sen1, rows[r].xen);
            chk($sformatf("row%0d_we", r), swe1, rows[r].xwe);
            chk($sformatf("row%0d_addr", r), saddr1, rows[r].xaddr);
            chk($sformatf("row%0d_wbe", r), swbe1, rows[r].xwbe);
            chk($sformatf("row%0d_wdata", r), swdata1,
                rows[r].xen ? wd(rows[r].xaddr) : 32'h0);
            chk($sformatf("row%0d_vld", r), vld1, rows[r].xvld);
            tick();
        end

        // Port 0 busy for three cycles; port 1 keeps changing its data while stalled.
        drive(4'b0011, 4'b0010, 9'h030, 9'h040, 9'h0, 9'h0, 4'hF);
        #1;
        chk("hold_c0_addr", saddr1, 9'h030);
        chk("hold_c0_rdy", rdy1[1], 1'b1);
        tick();
        drive(4'b0011, 4'b0010, 9'h030, 9'h041, 9'h0, 9'h0, 4'hF);
        #1;
        chk("hold_c1_addr", saddr1, 9'h030);
        chk("hold_c1_rdy", rdy1[1], 1'b0);
        tick();
        drive(4'b0011, 4'b0010, 9'h030, 9'h042, 9'h0, 9'h0, 4'hF);
        #1;
        chk("hold_c2_addr", saddr1, 9'h030);
        chk("hold_c2_rdy", rdy1[1], 1'b0);
        tick();
        drive(4'b0010, 4'b0010, 9'h0, 9'h042, 9'h0, 9'h0, 4'hF);
        #1;
        chk("hold_c3_en", sen1, 1'b1);
        chk("hold_c3_we", swe1, 1'b1);
        chk("hold_c3_addr", saddr1, 9'h040);
        chk("hold_c3_wdata", swdata1, wd(9'h040));
        tick();
        drive(4'b0, 4'b0, 9'h0, 9'h0, 9'h0, 9'h0, 4'hF);
        #1;
        chk("hold_c4_rdy", rdy1, 4'hF);
        chk("hold_c4_en", sen1, 1'b0);
        repeat (4) tick();

        // RD_LAT=3: port 1 read then port 0 read on consecutive cycles.
        drive(4'b0010, 4'b0, 9'h0, 9'h060, 9'h0, 9'h0, 4'hF);
        #1;
        chk("lat3_t0", vld3, 4'b0000);
        tick();
        drive(4'b0001, 4'b0, 9'h070, 9'h0, 9'h0, 9'h0, 4'hF);
        #1;
        chk("lat3_t1", vld3, 4'b0000);
        chk("lat1_t1", vld1, 4'b0010);
        tick();
        drive(4'b0, 4'b0, 9'h0, 9'h0, 9'h0, 9'h0, 4'hF);
        #1;
        chk("lat3_t2", vld3, 4'b0000);
        tick();
        #1;
        chk("lat3_t3", vld3, 4'b0010);
        tick();
        #1;
        chk("lat3_t4", vld3, 4'b0001);
        tick();
        #1;
        chk("lat3_t5", vld3, 4'b0000);
        tick();

        // Reset while port 3 is pending and a read tag is at the output.
        drive(4'b1001, 4'b0, 9'h050, 9'h0, 9'h0, 9'h053, 4'hF);
        #1;
        chk("rst_mid_addr", saddr1, 9'h050);
        tick();
        drive(4'b0, 4'b0, 9'h0, 9'h0, 9'h0, 9'h0, 4'hF);
        #1;
        chk("rst_mid_pend", rdy1, 4'b0111);
        chk("rst_mid_vld", vld1, 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("rst_async_vld", vld1, 4'b0000);
        chk("rst_async_rdy", rdy1, 4'hF);
        chk("rst_async_en", sen1, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("post_rst%0d_en", k), sen1, 1'b0);
            chk($sformatf("post_rst%0d_vld", k), vld1, 4'b0000);
            chk($sformatf("post_rst%0d_vld3", k), vld3, 4'b0000);
            tick();
        end
        drive(4'b1000, 4'b0, 9'h0, 9'h0, 9'h0, 9'h053, 4'hF);
        #1;
        chk("rereq_en", sen1, 1'b1);
        chk("rereq_addr", saddr1, 9'h053);
        tick();
        drive(4'b0, 4'b0, 9'h0, 9'h0, 9'h0, 9'h0, 4'hF);
        #1;
        chk("rereq_vld", vld1, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
